// File: rtl/sram_ctl_pkg.sv
// Shared definitions for the shared-SRAM switch controller.
// Holds the default queue count and data width used across the switch, the
// priority-index width, and the scheduler state encoding.
package sram_ctl_pkg;

    localparam int unsigned NUM_OF_PRIVILAGE = 8;
    localparam int unsigned DATA_WIDTH       = 64;
    localparam int unsigned PRI_W            = $clog2(NUM_OF_PRIVILAGE);

    typedef enum logic [0:0] {
        S_IDLE,
        S_BUSY
    } sched_state_e;

endpackage

// File: rtl/pri_sel.sv
// Highest-set-bit encoder used for strict-priority selection.
// Purely combinational; bit num_of_privilage-1 has the highest priority.
// Ports:
//   elig : request vector, one bit per priority queue
//   any  : at least one bit of elig is set
//   idx  : index of the highest set bit (0 when any=0)
module pri_sel
    import sram_ctl_pkg::*;
#(
    parameter int unsigned num_of_privilage = NUM_OF_PRIVILAGE,
    localparam int unsigned idx_w = $clog2(num_of_privilage)
) (
    input  logic [num_of_privilage-1:0] elig,
    output logic                        any,
    output logic [idx_w-1:0]            idx
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < int'(num_of_privilage); i++) begin
            if (elig[i]) begin
                any = 1'b1;
                idx = idx_w'(i);
            end
        end
    end

endmodule

// File: rtl/pkt_sched.sv
// Per-output-port packet scheduler.
// Counts complete packets queued per priority, grants the highest eligible
// priority (queued and downstream-ready) and holds the grant until the read
// engine signals end of packet, so packets never interleave.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   sched_en    : permits new grants; an in-flight packet always completes
//   enq_vld     : pulse, one complete packet committed to queue enq_pri
//   enq_pri     : target queue of enq_vld
//   ready       : per-priority downstream ready
//   pkt_done    : pulse, eop of the granted packet has been sent
//   sel_vld     : grant active
//   sel_pri     : granted queue, held while sel_vld=0
//   q_nonempty  : per-queue nonzero packet count
//   ovf_err     : pulse when an enqueue hits a saturated counter
// All outputs are registered.
module pkt_sched
    import sram_ctl_pkg::*;
#(
    parameter int unsigned num_of_privilage = NUM_OF_PRIVILAGE,
    parameter int unsigned cnt_width        = 8,
    localparam int unsigned pri_w = $clog2(num_of_privilage)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sched_en,
    input  logic                        enq_vld,
    input  logic [pri_w-1:0]            enq_pri,
    input  logic [num_of_privilage-1:0] ready,
    input  logic                        pkt_done,
    output logic                        sel_vld,
    output logic [pri_w-1:0]            sel_pri,
    output logic [num_of_privilage-1:0] q_nonempty,
    output logic                        ovf_err
);

    localparam logic [cnt_width-1:0] CntMax = {cnt_width{1'b1}};

    sched_state_e state;

    logic [cnt_width-1:0]        cnt     [num_of_privilage];
    logic [cnt_width-1:0]        cnt_nxt [num_of_privilage];
    logic [num_of_privilage-1:0] cnt_nz;
    logic [num_of_privilage-1:0] cnt_nxt_nz;
    logic [num_of_privilage-1:0] elig;
    logic                        elig_any;
    logic [pri_w-1:0]            elig_idx;
    logic                        grant;
    logic                        ovf_nxt;

    // Eligibility uses the registered counts, so an enqueue becomes
    // schedulable one cycle after it is counted.
    always_comb begin
        for (int p = 0; p < int'(num_of_privilage); p++) begin
            cnt_nz[p] = (cnt[p] != '0);
        end
        elig = cnt_nz & ready;
    end

    pri_sel #(
        .num_of_privilage (num_of_privilage)
    ) u_pri_sel (
        .elig (elig),
        .any  (elig_any),
        .idx  (elig_idx)
    );

    assign grant = (state == S_IDLE) && sched_en && elig_any;

    // Counter next-state: a simultaneous enqueue and grant on one queue nets
    // out; an enqueue onto a full counter is dropped and flagged unless the
    // same-cycle grant frees a slot.
    always_comb begin
        ovf_nxt = 1'b0;
        for (int p = 0; p < int'(num_of_privilage); p++) begin
            logic inc;
            logic dec;
            inc        = enq_vld && (enq_pri == pri_w'(p));
            dec        = grant && (elig_idx == pri_w'(p));
            cnt_nxt[p] = cnt[p];
            if (inc && !dec) begin
                if (cnt[p] == CntMax) begin
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt[p] = cnt[p] + 1'b1;
                end
            end else if (dec && !inc) begin
                cnt_nxt[p] = cnt[p] - 1'b1;
            end
            cnt_nxt_nz[p] = (cnt_nxt[p] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < int'(num_of_privilage); p++) begin
                cnt[p] <= '0;
            end
            q_nonempty <= '0;
            ovf_err    <= 1'b0;
        end else begin
            for (int p = 0; p < int'(num_of_privilage); p++) begin
                cnt[p] <= cnt_nxt[p];
            end
            q_nonempty <= cnt_nxt_nz;
            ovf_err    <= ovf_nxt;
        end
    end

    // Grant FSM. In BUSY, ready and sched_en are ignored: the packet is atomic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sel_vld <= 1'b0;
            sel_pri <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant) begin
                        state   <= S_BUSY;
                        sel_vld <= 1'b1;
                        sel_pri <= elig_idx;
                    end
                end
                S_BUSY: begin
                    if (pkt_done) begin
                        state   <= S_IDLE;
                        sel_vld <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    sel_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_sched.sv
module tb_pkt_sched;

    logic       clk;
    logic       rst_n;
    logic       sched_en;
    logic       enq_vld;
    logic [2:0] enq_pri;
    logic [7:0] ready;
    logic       pkt_done;
    logic       sel_vld;
    logic [2:0] sel_pri;
    logic [7:0] q_nonempty;
    logic       ovf_err;

    int tests;
    int fails;

    typedef struct {
        logic       enq_vld;
        logic [2:0] enq_pri;
        logic [7:0] ready;
        logic       sched_en;
        logic       pkt_done;
        logic       exp_vld;
        logic [2:0] exp_pri;
        logic [7:0] exp_qne;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    pkt_sched #(
        .num_of_privilage (8),
        .cnt_width        (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sched_en   (sched_en),
        .enq_vld    (enq_vld),
        .enq_pri    (enq_pri),
        .ready      (ready),
        .pkt_done   (pkt_done),
        .sel_vld    (sel_vld),
        .sel_pri    (sel_pri),
        .q_nonempty (q_nonempty),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the clock edge.
    task automatic step(input logic e, input logic [2:0] p, input logic [7:0] r,
                        input logic en, input logic d);
        enq_vld  = e;
        enq_pri  = p;
        ready    = r;
        sched_en = en;
        pkt_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic [2:0] p, input logic [7:0] r,
                       input logic en, input logic d, input logic ev,
                       input logic [2:0] ep, input logic [7:0] eq, input logic eo);
        vec_t v;
        v.enq_vld = e;  v.enq_pri = p;  v.ready = r;  v.sched_en = en;  v.pkt_done = d;
        v.exp_vld = ev; v.exp_pri = ep; v.exp_qne = eq; v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    initial begin
        int ovf_seen;
        int grants;
        int cyc;
        logic prev_vld;
        logic pd;
        string nm;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        enq_vld = 1'b0; enq_pri = '0; ready = '0; sched_en = 1'b0; pkt_done = 1'b0;

        //   enq pri ready   en done | vld pri qne    ovf
        // Priority order: 2 then 5 queued, 5 wins, 2 follows one idle cycle later.
        add(1, 2, 8'hFF, 0, 0,  0, 0, 8'h04, 0);
        add(1, 5, 8'hFF, 0, 0,  0, 0, 8'h24, 0);
        add(0, 0, 8'hFF, 1, 0,  1, 5, 8'h04, 0);
        add(0, 0, 8'hFF, 1, 0,  1, 5, 8'h04, 0);
        add(0, 0, 8'hFF, 1, 1,  0, 5, 8'h04, 0);
        add(0, 0, 8'hFF, 1, 0,  1, 2, 8'h00, 0);
        add(0, 0, 8'hFF, 1, 1,  0, 2, 8'h00, 0);
        add(0, 0, 8'hFF, 1, 1,  0, 2, 8'h00, 0);  // pkt_done in IDLE ignored
        // Ready gating: only 2 ready, raising ready[5] mid-packet changes nothing.
        add(1, 5, 8'hFF, 0, 0,  0, 2, 8'h20, 0);
        add(1, 2, 8'hFF, 0, 0,  0, 2, 8'h24, 0);
        add(0, 0, 8'h04, 1, 0,  1, 2, 8'h20, 0);
        add(0, 0, 8'hFF, 1, 0,  1, 2, 8'h20, 0);
        add(0, 0, 8'hFF, 1, 1,  0, 2, 8'h20, 0);
        add(0, 0, 8'hFF, 1, 0,  1, 5, 8'h00, 0);
        add(0, 0, 8'hFF, 1, 1,  0, 5, 8'h00, 0);
        // Same-cycle enqueue and grant on queue 3: count stays 1.
        add(1, 3, 8'hFF, 0, 0,  0, 5, 8'h08, 0);
        add(1, 3, 8'hFF, 1, 0,  1, 3, 8'h08, 0);
        add(0, 0, 8'hFF, 1, 1,  0, 3, 8'h08, 0);
        add(0, 0, 8'hFF, 1, 0,  1, 3, 8'h00, 0);
        add(0, 0, 8'hFF, 1, 1,  0, 3, 8'h00, 0);
        // Enqueue is not eligible in its own cycle; sched_en drop mid-packet.
        add(1, 1, 8'hFF, 1, 0,  0, 3, 8'h02, 0);
        add(0, 0, 8'hFF, 1, 0,  1, 1, 8'h00, 0);
        add(1, 6, 8'hFF, 0, 0,  1, 1, 8'h40, 0);
        add(0, 0, 8'hFF, 0, 0,  1, 1, 8'h40, 0);
        add(0, 0, 8'hFF, 0, 1,  0, 1, 8'h40, 0);
        add(0, 0, 8'hFF, 0, 0,  0, 1, 8'h40, 0);
        add(0, 0, 8'hFF, 0, 0,  0, 1, 8'h40, 0);
        add(0, 0, 8'hFF, 1, 0,  1, 6, 8'h00, 0);
        add(0, 0, 8'hFF, 1, 1,  0, 6, 8'h00, 0);
        // No ready: queued but no grant until ready[4] rises.
        add(1, 4, 8'h00, 1, 0,  0, 6, 8'h10, 0);
        add(0, 0, 8'h00, 1, 0,  0, 6, 8'h10, 0);
        add(0, 0, 8'h10, 1, 0,  1, 4, 8'h00, 0);
        add(0, 0, 8'h10, 1, 1,  0, 4, 8'h00, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {23'd0, sel_vld, sel_pri, q_nonempty, ovf_err}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].enq_vld, vecs[i].enq_pri, vecs[i].ready,
                 vecs[i].sched_en, vecs[i].pkt_done);
            nm = $sformatf("vec%0d{vld,pri,qne,ovf}", i);
            chk(nm, {19'd0, sel_vld, sel_pri, q_nonempty, ovf_err},
                {19'd0, vecs[i].exp_vld, vecs[i].exp_pri, vecs[i].exp_qne, vecs[i].exp_ovf});
        end

        // Asynchronous reset mid-BUSY with cnt[3]=2.
        repeat (3) step(1, 3, 8'hFF, 0, 0);
        step(0, 0, 8'hFF, 1, 0);
        chk("rst_pre_grant", {28'd0, sel_vld, sel_pri}, {28'd0, 1'b1, 3'd3});
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_vld", {31'd0, sel_vld}, 32'd0);
        chk("rst_async_qne", {24'd0, q_nonempty}, 32'd0);
        chk("rst_async_pri", {29'd0, sel_pri}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'hFF, 1, 0);
            chk("rst_no_grant", {23'd0, sel_vld, q_nonempty}, 32'd0);
        end
        step(1, 0, 8'hFF, 1, 0);
        chk("rst_new_enq", {23'd0, sel_vld, q_nonempty}, {23'd0, 1'b0, 8'h01});
        step(0, 0, 8'hFF, 1, 0);
        chk("rst_new_grant", {28'd0, sel_vld, sel_pri}, {28'd0, 1'b1, 3'd0});
        step(0, 0, 8'hFF, 1, 1);
        chk("rst_new_done", {31'd0, sel_vld}, 32'd0);

        // Saturation of queue 0 with scheduling disabled.
        ovf_seen = 0;
        for (int i = 0; i < 255; i++) begin
            step(1, 0, 8'hFF, 0, 0);
            if (ovf_err) ovf_seen++;
            if (sel_vld) ovf_seen += 1000;
        end
        chk("sat_fill_no_ovf_no_grant", ovf_seen, 0);
        chk("sat_fill_qne", {24'd0, q_nonempty}, 32'h01);
        step(1, 0, 8'hFF, 0, 0);
        chk("sat_ovf_pulse", {31'd0, ovf_err}, 32'd1);
        step(0, 0, 8'hFF, 0, 0);
        chk("sat_ovf_clear", {31'd0, ovf_err}, 32'd0);
        chk("sat_qne_hold", {24'd0, q_nonempty}, 32'h01);

        // Drain: count grants, bounded cycle budget.
        grants = 0;
        prev_vld = 1'b0;
        pd = 1'b0;
        cyc = 0;
        while (cyc < 2000) begin
            step(0, 0, 8'hFF, 1, pd);
            if (sel_vld && !prev_vld) grants++;
            prev_vld = sel_vld;
            pd = sel_vld;
            cyc++;
            if (!sel_vld && q_nonempty == 8'h00 && grants > 0) break;
        end
        chk("sat_drain_grants", grants, 255);
        chk("sat_drain_empty", {23'd0, sel_vld, q_nonempty}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'hFF, 1, 0);
            chk("sat_no_extra_grant", {31'd0, sel_vld}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pkt_sched.md
Name: pkt_sched

Overview:
- Per-output-port packet scheduler for the shared-SRAM switch. One instance sits in front of each of the 16 output ports.
- Tracks how many complete packets are queued in each of the 8 priority queues.
- Picks the next queue to drain with strict priority, gated by downstream per-priority ready.
- Holds the grant until the read engine reports end-of-packet, so packets are never interleaved on rd_data.

Parameters:
- num_of_privilage, 8, number of priority queues per output port; index 7 is the highest priority.
- cnt_width, 8, width of each per-queue packet counter; saturates at 2^cnt_width-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- sched_en  input  1  when high, new grants are allowed; when low, an in-flight packet still completes.
- enq_vld  input  1  one-cycle pulse: one complete packet (write eop seen) has been committed to queue enq_pri.
- enq_pri  input  $clog2(num_of_privilage)  target queue of enq_vld.
- ready  input  num_of_privilage  downstream can accept a packet of priority p.
- pkt_done  input  1  one-cycle pulse from read engine: eop of the granted packet has been sent.
- sel_vld  output  1  a grant is active.
- sel_pri  output  $clog2(num_of_privilage)  granted queue; stable while sel_vld=1.
- q_nonempty  output  num_of_privilage  bit p = (cnt[p] != 0), registered.
- ovf_err  output  1  one-cycle pulse when enq_vld hits a saturated counter.

Behaviour:
- Reset (rst_n low, async): state=IDLE, all cnt[p]=0, sel_vld=0, sel_pri=0, q_nonempty=0, ovf_err=0. Asserting rst_n mid-packet drops the grant immediately; no recovery is attempted.
- Counters:
  - cnt[p] increments on enq_vld with enq_pri=p and decrements on a grant to p.
  - Increment and decrement to the same p in the same cycle: cnt unchanged.
  - Increment at max: cnt holds and ovf_err pulses for 1 cycle.
  - Decrement at 0 cannot occur because eligibility requires cnt!=0.
- Eligibility: elig[p] = (cnt[p]!=0) & ready[p], using registered cnt. An enq at cycle t makes the queue eligible at t+1.
- Selection: highest p with elig[p]=1 (strict priority; 7 beats 0).
- FSM with 2 states:
  - IDLE: if sched_en & |elig, then at the clock edge go to BUSY, register sel_pri=selected p, set sel_vld=1, and decrement cnt[p]. Otherwise stay; sel_vld=0.
  - BUSY: sel_vld=1 and sel_pri held. ready changes are ignored (packet-atomic) and sched_en changes are ignored. On pkt_done, go to IDLE; sel_vld=0 from the next cycle.
- Latency:
  - Grant is visible 1 cycle after eligibility is sampled in IDLE.
  - Minimum gap between packets is 1 IDLE cycle: done at t, IDLE at t+1, new sel_vld at t+2.
- pkt_done in IDLE is ignored with no state change.
- sel_pri is held at its last value while sel_vld=0.
- Coincident events:
  - enq_vld and grant to different queues in the same cycle: both apply.
  - enq_vld during BUSY: counted normally.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package sram_ctl_pkg holds:
  - PRI_W = $clog2(num_of_privilage).
  - The state enum {S_IDLE, S_BUSY}.
  - The default num_of_privilage and data_width constants shared with the switch top level.
- Sub-module pri_sel: combinational highest-set-bit encoder, input elig[num_of_privilage-1:0], outputs any and idx[PRI_W-1:0]. It is reused by the write-side arbiter.
- Counters and FSM stay in pkt_sched.

Test Plan:
- Reset: drive rst_n=0 mid-BUSY with cnt[3]=2 -> sel_vld=0, q_nonempty=0 asynchronously; after release, no grant until a new enq.
- Priority order: ready=8'hFF, sched_en=1; enq pri 2 at t0, pri 5 at t1 -> first grant sel_pri=5; after pkt_done, grant sel_pri=2 exactly 2 cycles later; q_nonempty=0 at the end.
- Ready gating: cnt[5]=1, cnt[2]=1, ready=8'b0000_0100 -> grant 2. Then raise ready[5] while BUSY -> sel_pri stays 2 until pkt_done, then grants 5.
- Same-cycle enq/grant: cnt[3]=1, enq_vld pri 3 on the grant edge -> cnt[3] remains 1, q_nonempty[3]=1, second grant to 3 follows.
- Saturation: 255 enqs to pri 0 with sched_en=0 -> q_nonempty[0]=1, no grant. The 256th enq -> ovf_err pulses once. Then enable and drain 255 packets -> exactly 255 grants.
- sched_en deassert: drop sched_en while BUSY -> current grant holds until pkt_done. No new sel_vld while sched_en=0 even with cnt!=0; a grant follows 1 cycle after sched_en=1.
